// File: rtl/bus_pkg.sv
// Shared definitions for the CPU-to-slave bus decoder.
//   state_t          : decoder FSM encoding
//   SIZE_*           : access size codes carried on size/s_size
//   DEFAULT_ERR_DATA : read_data value returned with an error response
//   addr_match()     : base/mask region test used by the address matcher
package bus_pkg;

  // Widest address the match helper handles; callers zero-extend into it.
  localparam int unsigned MAX_AW = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEADBEEF;

  // A region matches when the masked address equals its base.
  function automatic logic addr_match(input logic [MAX_AW-1:0] addr,
                                      input logic [MAX_AW-1:0] base,
                                      input logic [MAX_AW-1:0] mask);
    return ((addr & mask) == base);
  endfunction

endpackage

// File: rtl/bus_decoder_if.sv
// CPU-side request/response bundle of the bus decoder.
//   address, rw_req, rw, write_data, size : request from the CPU (master)
//   read_data, rec                        : registered response from the decoder
// master modport is the CPU view, slave modport is the decoder view.
interface bus_decoder_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);

  logic [AW-1:0] address;
  logic          rw_req;
  logic          rw;
  logic [DW-1:0] write_data;
  logic [1:0]    size;
  logic [DW-1:0] read_data;
  logic          rec;

  modport master (
    output address, rw_req, rw, write_data, size,
    input  read_data, rec
  );

  modport slave (
    input  address, rw_req, rw, write_data, size,
    output read_data, rec
  );

endinterface

// File: rtl/bus_addr_match.sv
// Combinational NSLAVE-way priority address matcher.
//   address : CPU address
//   hit     : at least one region matches
//   sel     : index of the lowest-numbered matching region (0 when no hit)
// Regions come from the packed SLAVE_BASE/SLAVE_MASK tables, slave i at [i*AW +: AW].
module bus_addr_match
  import bus_pkg::*;
#(
  parameter int unsigned          NSLAVE     = 2,
  parameter int unsigned          AW         = 32,
  parameter int unsigned          SW         = 1,
  parameter logic [NSLAVE*AW-1:0] SLAVE_BASE = {32'h80000000, 32'h00000000},
  parameter logic [NSLAVE*AW-1:0] SLAVE_MASK = {32'h80000000, 32'h80000000}
) (
  input  logic [AW-1:0] address,
  output logic          hit,
  output logic [SW-1:0] sel
);

  // Scan from the top down so the lowest matching index is written last.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = int'(NSLAVE) - 1; i >= 0; i--) begin
      if (addr_match(MAX_AW'(address),
                     MAX_AW'(SLAVE_BASE[i*AW +: AW]),
                     MAX_AW'(SLAVE_MASK[i*AW +: AW]))) begin
        hit = 1'b1;
        sel = SW'(i);
      end
    end
  end

endmodule

// File: rtl/bus_decoder.sv
// CPU-to-slave memory bus decoder.
//   clk, reset     : bus clock, synchronous active-high reset
//   cpu            : CPU request/response (bus_decoder_if.slave)
//   s_address, s_rw, s_write_data, s_size : latched request shared by all slaves
//   s_rw_req       : one-hot request, held until the selected slave's s_rec
//   s_read_data    : per-slave read data, slave i at [i*DW +: DW]
//   s_rec          : per-slave data-valid
//   bus_err        : one-cycle pulse with an error response
//   err_sticky     : set on any error until reset
//   err_addr       : address of the most recent error
//   busy           : decoder not idle
// Each request is routed to the lowest-index matching slave; unmapped
// addresses and slaves that exceed TIMEOUT wait cycles get an ERR_DATA
// response flagged by bus_err.
module bus_decoder
  import bus_pkg::*;
#(
  parameter int unsigned          NSLAVE     = 2,
  parameter int unsigned          AW         = 32,
  parameter int unsigned          DW         = 32,
  parameter logic [NSLAVE*AW-1:0] SLAVE_BASE = {32'h80000000, 32'h00000000},
  parameter logic [NSLAVE*AW-1:0] SLAVE_MASK = {32'h80000000, 32'h80000000},
  parameter int unsigned          TIMEOUT    = 1023,
  parameter logic [DW-1:0]        ERR_DATA   = DW'(DEFAULT_ERR_DATA)
) (
  input  logic                 clk,
  input  logic                 reset,
  bus_decoder_if.slave         cpu,
  output logic [AW-1:0]        s_address,
  output logic                 s_rw,
  output logic [DW-1:0]        s_write_data,
  output logic [1:0]           s_size,
  output logic [NSLAVE-1:0]    s_rw_req,
  input  logic [NSLAVE*DW-1:0] s_read_data,
  input  logic [NSLAVE-1:0]    s_rec,
  output logic                 bus_err,
  output logic                 err_sticky,
  output logic [AW-1:0]        err_addr,
  output logic                 busy
);

  localparam int unsigned SW = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t              state_q, state_nxt;
  logic [CW-1:0]       cnt_q, cnt_nxt;
  logic [SW-1:0]       sel_q, sel_nxt;
  logic                unmapped_q, unmapped_nxt;
  logic [DW-1:0]       read_data_q, read_data_nxt;
  logic                rec_q, rec_nxt;
  logic [AW-1:0]       s_address_nxt;
  logic                s_rw_nxt;
  logic [DW-1:0]       s_write_data_nxt;
  logic [1:0]          s_size_nxt;
  logic [NSLAVE-1:0]   s_rw_req_nxt;
  logic                bus_err_nxt;
  logic                err_sticky_nxt;
  logic [AW-1:0]       err_addr_nxt;

  logic                hit_c;
  logic [SW-1:0]       sel_c;
  logic                sel_rec_c;
  logic [DW-1:0]       sel_data_c;

  bus_addr_match #(
    .NSLAVE     (NSLAVE),
    .AW         (AW),
    .SW         (SW),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_match (
    .address (cpu.address),
    .hit     (hit_c),
    .sel     (sel_c)
  );

  // Response of the slave latched at accept; others are never looked at.
  always_comb begin
    sel_rec_c  = 1'b0;
    sel_data_c = '0;
    for (int unsigned i = 0; i < NSLAVE; i++) begin
      if (sel_q == SW'(i)) begin
        sel_rec_c  = s_rec[i];
        sel_data_c = s_read_data[i*DW +: DW];
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt        = state_q;
    cnt_nxt          = cnt_q;
    sel_nxt          = sel_q;
    unmapped_nxt     = unmapped_q;
    read_data_nxt    = read_data_q;
    rec_nxt          = 1'b0;
    s_address_nxt    = s_address;
    s_rw_nxt         = s_rw;
    s_write_data_nxt = s_write_data;
    s_size_nxt       = s_size;
    s_rw_req_nxt     = s_rw_req;
    bus_err_nxt      = 1'b0;
    err_sticky_nxt   = err_sticky;
    err_addr_nxt     = err_addr;

    unique case (state_q)
      ST_IDLE: begin
        if (cpu.rw_req) begin
          if (hit_c) begin
            s_address_nxt    = cpu.address;
            s_rw_nxt         = cpu.rw;
            s_write_data_nxt = cpu.write_data;
            s_size_nxt       = cpu.size;
            s_rw_req_nxt     = NSLAVE'(1) << sel_c;
            sel_nxt          = sel_c;
            cnt_nxt          = '0;
            unmapped_nxt     = 1'b0;
            state_nxt        = ST_WAIT;
          end else begin
            unmapped_nxt     = 1'b1;
            state_nxt        = ST_ERR;
          end
        end
      end

      ST_WAIT: begin
        // A response in the expiry cycle still completes normally.
        if (sel_rec_c) begin
          read_data_nxt = sel_data_c;
          rec_nxt       = 1'b1;
          s_rw_req_nxt  = '0;
          state_nxt     = ST_DONE;
        end else if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT))) begin
          s_rw_req_nxt  = '0;
          state_nxt     = ST_ERR;
        end else if (cnt_q != '1) begin
          cnt_nxt       = cnt_q + CW'(1);
        end
      end

      ST_ERR: begin
        rec_nxt        = 1'b1;
        bus_err_nxt    = 1'b1;
        read_data_nxt  = ERR_DATA;
        // Unmapped requests never reach s_address; the CPU still holds it.
        err_addr_nxt   = unmapped_q ? cpu.address : s_address;
        err_sticky_nxt = 1'b1;
        state_nxt      = ST_DONE;
      end

      ST_DONE: begin
        // Turnaround cycle lets the CPU drop rw_req after rec.
        state_nxt = ST_IDLE;
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      sel_q        <= '0;
      unmapped_q   <= 1'b0;
      read_data_q  <= '0;
      rec_q        <= 1'b0;
      s_address    <= '0;
      s_rw         <= 1'b0;
      s_write_data <= '0;
      s_size       <= '0;
      s_rw_req     <= '0;
      bus_err      <= 1'b0;
      err_sticky   <= 1'b0;
      err_addr     <= '0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      cnt_q        <= cnt_nxt;
      sel_q        <= sel_nxt;
      unmapped_q   <= unmapped_nxt;
      read_data_q  <= read_data_nxt;
      rec_q        <= rec_nxt;
      s_address    <= s_address_nxt;
      s_rw         <= s_rw_nxt;
      s_write_data <= s_write_data_nxt;
      s_size       <= s_size_nxt;
      s_rw_req     <= s_rw_req_nxt;
      bus_err      <= bus_err_nxt;
      err_sticky   <= err_sticky_nxt;
      err_addr     <= err_addr_nxt;
      busy         <= (state_nxt != ST_IDLE);
    end
  end

  assign cpu.read_data = read_data_q;
  assign cpu.rec       = rec_q;

endmodule

// File: tb/tb_bus_decoder.sv
// Bench for bus_decoder: two instances (2-slave default map with TIMEOUT=15,
// and a 3-slave map with overlap and an unmapped hole). Expected responses are
// queued when a request is issued and checked when rec pulses.
module tb_bus_decoder;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n;

  exp_t exp_a[$];
  exp_t exp_b[$];
  exp_t ea, eb;
  logic rec_a_prev = 1'b0;
  logic rec_b_prev = 1'b0;

  // instance A
  bus_decoder_if #(.AW(32), .DW(32)) cpu_a();
  logic [31:0] s_address_a, s_write_data_a, err_addr_a;
  logic        s_rw_a, bus_err_a, err_sticky_a, busy_a;
  logic [1:0]  s_size_a, s_rw_req_a, s_rec_a;
  logic [63:0] s_rd_a;

  bus_decoder #(.NSLAVE(2), .TIMEOUT(15)) dut_a (
    .clk          (clk),
    .reset        (reset),
    .cpu          (cpu_a),
    .s_address    (s_address_a),
    .s_rw         (s_rw_a),
    .s_write_data (s_write_data_a),
    .s_size       (s_size_a),
    .s_rw_req     (s_rw_req_a),
    .s_read_data  (s_rd_a),
    .s_rec        (s_rec_a),
    .bus_err      (bus_err_a),
    .err_sticky   (err_sticky_a),
    .err_addr     (err_addr_a),
    .busy         (busy_a)
  );

  // instance B: slave0 0x0/0x8, slave1 0xC/0xC, slave2 0x4/0xC (top nibble)
  bus_decoder_if #(.AW(32), .DW(32)) cpu_b();
  logic [31:0] s_address_b, s_write_data_b, err_addr_b;
  logic        s_rw_b, bus_err_b, err_sticky_b, busy_b;
  logic [1:0]  s_size_b;
  logic [2:0]  s_rw_req_b, s_rec_b;
  logic [95:0] s_rd_b;

  bus_decoder #(
    .NSLAVE     (3),
    .SLAVE_BASE ({32'h40000000, 32'hC0000000, 32'h00000000}),
    .SLAVE_MASK ({32'hC0000000, 32'hC0000000, 32'h80000000})
  ) dut_b (
    .clk          (clk),
    .reset        (reset),
    .cpu          (cpu_b),
    .s_address    (s_address_b),
    .s_rw         (s_rw_b),
    .s_write_data (s_write_data_b),
    .s_size       (s_size_b),
    .s_rw_req     (s_rw_req_b),
    .s_read_data  (s_rd_b),
    .s_rec        (s_rec_b),
    .bus_err      (bus_err_b),
    .err_sticky   (err_sticky_b),
    .err_addr     (err_addr_b),
    .busy         (busy_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int cycles = 1);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard monitors: every rec pulse must match the oldest queued response.
  always @(negedge clk) begin
    if (!reset) begin
      if (cpu_a.rec) begin
        if (exp_a.size() == 0) chk("a_rec_unexpected", 64'd1, 64'd0);
        else begin
          ea = exp_a.pop_front();
          chk("a_read_data", 64'(cpu_a.read_data), 64'(ea.d));
          chk("a_bus_err", 64'(bus_err_a), 64'(ea.e));
        end
      end
      if (cpu_a.rec && rec_a_prev) chk("a_rec_twice", 64'd1, 64'd0);
      if (cpu_b.rec) begin
        if (exp_b.size() == 0) chk("b_rec_unexpected", 64'd1, 64'd0);
        else begin
          eb = exp_b.pop_front();
          chk("b_read_data", 64'(cpu_b.read_data), 64'(eb.d));
          chk("b_bus_err", 64'(bus_err_b), 64'(eb.e));
        end
      end
      if (cpu_b.rec && rec_b_prev) chk("b_rec_twice", 64'd1, 64'd0);
    end
    rec_a_prev = cpu_a.rec;
    rec_b_prev = cpu_b.rec;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    cpu_a.address = '0; cpu_a.rw_req = 1'b0; cpu_a.rw = 1'b0;
    cpu_a.write_data = '0; cpu_a.size = 2'd2;
    cpu_b.address = '0; cpu_b.rw_req = 1'b0; cpu_b.rw = 1'b0;
    cpu_b.write_data = '0; cpu_b.size = 2'd2;
    s_rd_a = '0; s_rec_a = '0; s_rd_b = '0; s_rec_b = '0;
    tick(2);

    // reset state
    chk("rst_read_data", 64'(cpu_a.read_data), 64'd0);
    chk("rst_rec", 64'(cpu_a.rec), 64'd0);
    chk("rst_s_rw_req", 64'(s_rw_req_a), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_err_sticky", 64'(err_sticky_a), 64'd0);
    chk("rst_err_addr", 64'(err_addr_a), 64'd0);
    chk("rst_s_address", 64'(s_address_a), 64'd0);
    reset = 1'b0;
    tick();

    // read from slave0, response 3 cycles after s_rw_req
    cpu_a.address = 32'h00000100; cpu_a.rw = 1'b0; cpu_a.rw_req = 1'b1;
    exp_a.push_back(exp_t'{d: 32'h12345678, e: 1'b0});
    tick();
    chk("rd_s_rw_req", 64'(s_rw_req_a), 64'h1);
    chk("rd_s_address", 64'(s_address_a), 64'h100);
    chk("rd_busy", 64'(busy_a), 64'd1);
    tick(3);
    chk("rd_rec_early", 64'(cpu_a.rec), 64'd0);
    s_rd_a[31:0] = 32'h12345678; s_rec_a = 2'b01;
    tick();
    chk("rd_rec", 64'(cpu_a.rec), 64'd1);
    chk("rd_data", 64'(cpu_a.read_data), 64'h12345678);
    chk("rd_s_rw_req_clr", 64'(s_rw_req_a), 64'd0);
    s_rec_a = '0; cpu_a.rw_req = 1'b0;
    tick();
    chk("rd_rec_drop", 64'(cpu_a.rec), 64'd0);
    chk("rd_data_hold", 64'(cpu_a.read_data), 64'h12345678);
    tick();

    // write to slave1, stray s_rec from slave0 first
    cpu_a.address = 32'h80000004; cpu_a.rw = 1'b1; cpu_a.write_data = 32'hA5;
    cpu_a.size = 2'd0; cpu_a.rw_req = 1'b1;
    exp_a.push_back(exp_t'{d: 32'hCAFE0001, e: 1'b0});
    tick();
    chk("wr_s_rw_req", 64'(s_rw_req_a), 64'h2);
    chk("wr_s_address", 64'(s_address_a), 64'h80000004);
    chk("wr_s_write_data", 64'(s_write_data_a), 64'hA5);
    chk("wr_s_rw", 64'(s_rw_a), 64'd1);
    chk("wr_s_size", 64'(s_size_a), 64'd0);
    s_rec_a = 2'b01;
    tick();
    chk("wr_wrong_slave_ignored", 64'(cpu_a.rec), 64'd0);
    chk("wr_s_rw_req_held", 64'(s_rw_req_a), 64'h2);
    s_rec_a = 2'b10; s_rd_a[63:32] = 32'hCAFE0001;
    tick();
    chk("wr_rec", 64'(cpu_a.rec), 64'd1);
    s_rec_a = '0; cpu_a.rw_req = 1'b0; cpu_a.rw = 1'b0; cpu_a.size = 2'd2;
    tick(2);

    // timeout: slave never answers
    cpu_a.address = 32'h00000200; cpu_a.rw_req = 1'b1;
    exp_a.push_back(exp_t'{d: 32'hDEADBEEF, e: 1'b1});
    tick();
    n = 0;
    while (s_rw_req_a != '0 && n < 100) begin
      n++;
      tick();
    end
    chk("to_wait_cycles", 64'(n), 64'd16);
    chk("to_rec_not_yet", 64'(cpu_a.rec), 64'd0);
    s_rec_a = 2'b01;
    tick();
    chk("to_rec", 64'(cpu_a.rec), 64'd1);
    chk("to_bus_err", 64'(bus_err_a), 64'd1);
    chk("to_data", 64'(cpu_a.read_data), 64'hDEADBEEF);
    chk("to_err_addr", 64'(err_addr_a), 64'h200);
    chk("to_err_sticky", 64'(err_sticky_a), 64'd1);
    cpu_a.rw_req = 1'b0;
    tick();
    chk("to_late_rec_ignored", 64'(cpu_a.rec), 64'd0);
    chk("to_bus_err_pulse", 64'(bus_err_a), 64'd0);
    tick();
    chk("to_idle", 64'(busy_a), 64'd0);
    s_rec_a = '0;
    tick();

    // s_rec in the expiry cycle wins over the timeout
    cpu_a.address = 32'h00000204; cpu_a.rw_req = 1'b1;
    exp_a.push_back(exp_t'{d: 32'h55AA55AA, e: 1'b0});
    tick();
    tick(15);
    chk("race_still_waiting", 64'(s_rw_req_a), 64'h1);
    s_rec_a = 2'b01; s_rd_a[31:0] = 32'h55AA55AA;
    tick();
    chk("race_rec", 64'(cpu_a.rec), 64'd1);
    chk("race_no_err", 64'(bus_err_a), 64'd0);
    s_rec_a = '0; cpu_a.rw_req = 1'b0;
    tick(2);

    // reset during WAIT, then a stray s_rec
    cpu_a.address = 32'h00000300; cpu_a.rw_req = 1'b1;
    tick();
    chk("rstw_s_rw_req", 64'(s_rw_req_a), 64'h1);
    reset = 1'b1;
    tick();
    chk("rstw_s_rw_req_drop", 64'(s_rw_req_a), 64'd0);
    chk("rstw_busy", 64'(busy_a), 64'd0);
    chk("rstw_err_sticky", 64'(err_sticky_a), 64'd0);
    chk("rstw_read_data", 64'(cpu_a.read_data), 64'd0);
    chk("rstw_err_addr", 64'(err_addr_a), 64'd0);
    cpu_a.rw_req = 1'b0;
    reset = 1'b0;
    s_rec_a = 2'b01; s_rd_a[31:0] = 32'h99999999;
    tick();
    chk("rstw_stray_rec", 64'(cpu_a.rec), 64'd0);
    tick();
    chk("rstw_stray_busy", 64'(busy_a), 64'd0);
    s_rec_a = '0;
    tick();
    cpu_a.address = 32'h00000104; cpu_a.rw_req = 1'b1;
    exp_a.push_back(exp_t'{d: 32'h11112222, e: 1'b0});
    tick();
    s_rec_a = 2'b01; s_rd_a[31:0] = 32'h11112222;
    tick();
    chk("rstw_next_rec", 64'(cpu_a.rec), 64'd1);
    chk("rstw_next_sticky", 64'(err_sticky_a), 64'd0);
    s_rec_a = '0; cpu_a.rw_req = 1'b0;
    tick(2);

    // B: unmapped address -> error 2 cycles after rw_req, no slave request
    cpu_b.address = 32'h80000000; cpu_b.rw_req = 1'b1;
    exp_b.push_back(exp_t'{d: 32'hDEADBEEF, e: 1'b1});
    tick();
    chk("um_no_s_rw_req0", 64'(s_rw_req_b), 64'd0);
    chk("um_rec_early", 64'(cpu_b.rec), 64'd0);
    tick();
    chk("um_rec", 64'(cpu_b.rec), 64'd1);
    chk("um_bus_err", 64'(bus_err_b), 64'd1);
    chk("um_err_addr", 64'(err_addr_b), 64'h80000000);
    chk("um_no_s_rw_req1", 64'(s_rw_req_b), 64'd0);
    cpu_b.rw_req = 1'b0;
    tick(2);

    // B: overlap 0x40000010 -> slave0; slave2 s_rec ignored
    cpu_b.address = 32'h40000010; cpu_b.rw_req = 1'b1;
    exp_b.push_back(exp_t'{d: 32'h0000AAAA, e: 1'b0});
    tick();
    chk("ov_s_rw_req", 64'(s_rw_req_b), 64'h1);
    s_rec_b = 3'b100; s_rd_b[95:64] = 32'h77777777;
    tick();
    chk("ov_slave2_ignored", 64'(cpu_b.rec), 64'd0);
    s_rec_b = 3'b001; s_rd_b[31:0] = 32'h0000AAAA;
    tick();
    chk("ov_rec", 64'(cpu_b.rec), 64'd1);
    s_rec_b = '0; cpu_b.rw_req = 1'b0;
    tick(2);

    // B: address exactly at slave1 base
    cpu_b.address = 32'hC0000000; cpu_b.rw_req = 1'b1;
    exp_b.push_back(exp_t'{d: 32'h0000BBBB, e: 1'b0});
    tick();
    chk("base_s_rw_req", 64'(s_rw_req_b), 64'h2);
    s_rec_b = 3'b010; s_rd_b[63:32] = 32'h0000BBBB;
    tick();
    chk("base_rec", 64'(cpu_b.rec), 64'd1);
    chk("base_sticky_kept", 64'(err_sticky_b), 64'd1);
    s_rec_b = '0; cpu_b.rw_req = 1'b0;
    tick(3);

    chk("a_queue_drained", 64'(exp_a.size()), 64'd0);
    chk("b_queue_drained", 64'(exp_b.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
